// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared LFSR tap constants and step functions
package lfsr_pkg;

    localparam logic [31:0] TAPS_W8  = 32'h0000_0063;
    localparam logic [31:0] TAPS_W16 = 32'h0000_B401;
    localparam logic [31:0] TAPS_W32 = 32'hA300_0001;

    function automatic logic [31:0] width_mask(input int unsigned width);
        return (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    endfunction

    // Any odd mask keeps the step invertible; the listed widths get long-period taps.
    function automatic logic [31:0] default_taps(input int unsigned width);
        case (width)
            8:       return TAPS_W8;
            16:      return TAPS_W16;
            32:      return TAPS_W32;
            default: return ((32'd1 << (width - 1)) | 32'd1) & width_mask(width);
        endcase
    endfunction

    function automatic logic [31:0] reverse_mask(input logic [31:0] taps,
                                                 input int unsigned width);
        return ((32'd1 << (width - 1)) | ((taps & width_mask(width)) >> 1)) & width_mask(width);
    endfunction

    function automatic logic [31:0] lfsr_fwd(input logic [31:0] state,
                                             input logic [31:0] taps,
                                             input int unsigned width);
        logic [31:0] s;
        logic        fb;
        s  = state & width_mask(width);
        fb = ~^(s & taps);
        return ((s >> 1) | ({31'd0, fb} << (width - 1))) & width_mask(width);
    endfunction

    function automatic logic [31:0] lfsr_rev(input logic [31:0] state,
                                             input logic [31:0] rmask,
                                             input int unsigned width);
        logic [31:0] s;
        logic        rb;
        s  = state & width_mask(width);
        rb = ~^(s & rmask);
        return ((s << 1) | {31'd0, rb}) & width_mask(width);
    endfunction

endpackage

// File: rtl/lfsr_step_core.sv
// rtl/lfsr_step_core.sv - combinational XNOR Fibonacci forward/reverse step
module lfsr_step_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] state,
    input  logic [WIDTH-1:0] taps,
    input  logic             up_down,
    output logic [WIDTH-1:0] next_state
);

    logic [WIDTH-1:0] rmask;
    logic             fb;
    logic             rb;

    // The bit shifted out forward is recovered by folding the new MSB back in with taps[0].
    always_comb begin
        rmask      = {1'b1, taps[WIDTH-1:1]};
        fb         = ~^(state & taps);
        rb         = ~^(state & rmask);
        next_state = up_down ? {fb, state[WIDTH-1:1]} : {state[WIDTH-2:0], rb};
    end

endmodule

// File: rtl/lfsr_seq_gen.sv
// rtl/lfsr_seq_gen.sv - bidirectional LFSR sequencer with seed load, terminal count and offset
module lfsr_seq_gen
    import lfsr_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(default_taps(WIDTH)),
    parameter int unsigned      OFS_W = WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic [WIDTH-1:0] term_value,
    output logic [WIDTH-1:0] count,
    output logic [OFS_W-1:0] offset,
    output logic             tc,
    output logic             lock_err
);

    localparam logic [WIDTH-1:0] LOCKUP = '1;

    logic [WIDTH-1:0] step_next;
    logic             seed_ok;

    lfsr_step_core #(
        .WIDTH(WIDTH)
    ) u_step_core (
        .state     (count),
        .taps      (TAPS),
        .up_down   (up_down),
        .next_state(step_next)
    );

    assign seed_ok = (seed != LOCKUP);

    // All-ones is the XNOR lock-up state; refusing it at load keeps it unreachable.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count    <= '0;
            offset   <= '0;
            tc       <= 1'b0;
            lock_err <= 1'b0;
        end else begin
            tc <= 1'b0;
            if (load) begin
                if (seed_ok) begin
                    count  <= seed;
                    offset <= '0;
                end else begin
                    lock_err <= 1'b1;
                end
            end else if (enable) begin
                count  <= step_next;
                offset <= up_down ? offset + OFS_W'(1) : offset - OFS_W'(1);
                tc     <= (step_next == term_value);
            end
        end
    end

endmodule

// File: tb/tb_lfsr_seq_gen.sv
// tb/tb_lfsr_seq_gen.sv - directed self-checking bench for lfsr_seq_gen
module tb_lfsr_seq_gen;
    import lfsr_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;

    logic        enable8, up_down8, load8;
    logic [7:0]  seed8, term8;
    logic [7:0]  count8, offset8;
    logic        tc8, lock8;

    logic        enable16, up_down16, load16;
    logic [15:0] seed16, term16;
    logic [15:0] count16, offset16;
    logic        tc16, lock16;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    lfsr_seq_gen dut8 (
        .clk(clk), .reset_n(reset_n), .enable(enable8), .up_down(up_down8),
        .load(load8), .seed(seed8), .term_value(term8),
        .count(count8), .offset(offset8), .tc(tc8), .lock_err(lock8)
    );

    lfsr_seq_gen #(.WIDTH(16), .TAPS(16'hB401), .OFS_W(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .enable(enable16), .up_down(up_down16),
        .load(load16), .seed(seed16), .term_value(term16),
        .count(count16), .offset(offset16), .tc(tc16), .lock_err(lock16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step8(input logic dir);
        enable8  = 1'b1;
        up_down8 = dir;
        tick();
        enable8  = 1'b0;
    endtask

    task automatic load8_seed(input logic [7:0] s);
        load8 = 1'b1;
        seed8 = s;
        tick();
        load8 = 1'b0;
    endtask

    task automatic chk8(input string tag, input logic [7:0] c, input logic [7:0] o,
                        input logic t);
        chk({tag, ".count"},  {24'd0, count8},  {24'd0, c});
        chk({tag, ".offset"}, {24'd0, offset8}, {24'd0, o});
        chk({tag, ".tc"},     {31'd0, tc8},     {31'd0, t});
    endtask

    initial begin
        logic [7:0]  ref_c, ref_o;
        logic [15:0] ref16;
        logic        dir;

        reset_n  = 1'b0;
        enable8  = 1'b0; up_down8  = 1'b1; load8  = 1'b0; seed8  = '0; term8  = 8'h01;
        enable16 = 1'b0; up_down16 = 1'b1; load16 = 1'b0; seed16 = '0; term16 = 16'hFFFF;
        tick();
        tick();
        chk8("reset", 8'h00, 8'h00, 1'b0);
        chk("reset.lock_err", {31'd0, lock8}, 32'd0);
        chk("reset.count16", {16'd0, count16}, 32'd0);
        reset_n = 1'b1;
        tick();

        // forward then reverse walk from zero
        step8(1'b1); chk8("fwd1", 8'h80, 8'd1, 1'b0);
        step8(1'b1); chk8("fwd2", 8'hC0, 8'd2, 1'b0);
        step8(1'b1); chk8("fwd3", 8'h60, 8'd3, 1'b0);
        step8(1'b0); chk8("rev1", 8'hC0, 8'd2, 1'b0);
        step8(1'b0); chk8("rev2", 8'h80, 8'd1, 1'b0);
        step8(1'b0); chk8("rev3", 8'h00, 8'd0, 1'b0);

        // terminal count: one pulse, none while holding, none on load
        term8 = 8'hC0;
        step8(1'b1); chk8("tc_fwd1", 8'h80, 8'd1, 1'b0);
        step8(1'b1); chk8("tc_hit",  8'hC0, 8'd2, 1'b1);
        tick();      chk8("tc_hold", 8'hC0, 8'd2, 1'b0);
        load8_seed(8'hC0); chk8("tc_load", 8'hC0, 8'd0, 1'b0);
        tick();      chk8("tc_load2", 8'hC0, 8'd0, 1'b0);

        // random directions against the package model
        load8_seed(8'h5A); chk8("seed5a", 8'h5A, 8'd0, 1'b0);
        ref_c = 8'h5A;
        ref_o = 8'd0;
        for (int i = 0; i < 200; i++) begin
            dir = 1'($urandom_range(0, 1));
            if (dir) begin
                ref_c = 8'(lfsr_fwd({24'd0, ref_c}, TAPS_W8, 8));
                ref_o = ref_o + 8'd1;
            end else begin
                ref_c = 8'(lfsr_rev({24'd0, ref_c}, reverse_mask(TAPS_W8, 8), 8));
                ref_o = ref_o - 8'd1;
            end
            step8(dir);
            chk8("rand", ref_c, ref_o, ref_c == 8'hC0);
        end

        // lock-up seed rejected, flag sticky
        term8 = 8'h01;
        load8_seed(8'h00); chk8("lk_seed0", 8'h00, 8'd0, 1'b0);
        step8(1'b1);       chk8("lk_fwd",   8'h80, 8'd1, 1'b0);
        load8_seed(8'hFF); chk8("lk_reject", 8'h80, 8'd1, 1'b0);
        chk("lk_flag", {31'd0, lock8}, 32'd1);
        step8(1'b1);       chk8("lk_step", 8'hC0, 8'd2, 1'b0);
        chk("lk_sticky", {31'd0, lock8}, 32'd1);

        // load wins over enable, no tc from load
        term8   = 8'h11;
        load8   = 1'b1; seed8 = 8'h11; enable8 = 1'b1; up_down8 = 1'b1;
        tick();
        load8   = 1'b0; enable8 = 1'b0;
        chk8("ld_prio", 8'h11, 8'd0, 1'b0);
        chk("ld_prio.lock", {31'd0, lock8}, 32'd1);

        // async reset mid-operation clears a pending tc
        term8 = 8'h08;
        step8(1'b1); chk8("pre_rst", 8'h08, 8'd1, 1'b1);
        #3 reset_n = 1'b0;
        #1;
        chk8("async_rst", 8'h00, 8'h00, 1'b0);
        chk("async_rst.lock", {31'd0, lock8}, 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // offset wraps below zero
        term8 = 8'h55;
        step8(1'b0); chk8("wrap_rev", 8'h01, 8'hFF, 1'b0);
        step8(1'b1); chk8("wrap_fwd", 8'h00, 8'h00, 1'b0);

        // 16-bit instance: first step, then 1000 forward and 1000 back
        enable16 = 1'b1; up_down16 = 1'b1;
        tick();
        enable16 = 1'b0;
        chk("w16.fwd1", {16'd0, count16}, 32'h8000);
        chk("w16.off1", {16'd0, offset16}, 32'd1);
        load16 = 1'b1; seed16 = 16'h1234;
        tick();
        load16 = 1'b0;
        chk("w16.seed", {16'd0, count16}, 32'h1234);
        ref16 = 16'h1234;
        for (int i = 0; i < 1000; i++)
            ref16 = 16'(lfsr_fwd({16'd0, ref16}, 32'h0000_B401, 16));
        enable16 = 1'b1; up_down16 = 1'b1;
        repeat (1000) tick();
        enable16 = 1'b0;
        chk("w16.fwd1000", {16'd0, count16}, {16'd0, ref16});
        chk("w16.off1000", {16'd0, offset16}, 32'd1000);
        enable16 = 1'b1; up_down16 = 1'b0;
        repeat (1000) tick();
        enable16 = 1'b0;
        chk("w16.back", {16'd0, count16}, 32'h1234);
        chk("w16.off0", {16'd0, offset16}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/lfsr_seq_gen.md
Name: lfsr_seq_gen

Overview:
- Parametrised XNOR Fibonacci LFSR sequencer, bidirectional. Generalises the fixed 8-bit up/down LFSR counter.
- Width and tap mask are parameters. The reverse-step mask is derived, so the down step is the exact inverse of the up step.
- Adds seed load, a programmable terminal-count compare, lock-up protection and a signed step-offset tracker.
- Used as the programmable pseudo-random address/timer source for the datapath test and scrambling logic.

Parameters:
- WIDTH, 8: LFSR state width; legal range 3..32.
- TAPS, 8'h63 (WIDTH bits): forward feedback mask. Bit 0 must be set, otherwise the step is not invertible.
- OFS_W, WIDTH: width of the step-offset counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous active-low reset.
- enable  in  1  advance one step this cycle.
- up_down  in  1  1 = forward step, 0 = reverse step.
- load  in  1  load seed this cycle.
- seed  in  WIDTH  value written by load.
- term_value  in  WIDTH  terminal-count compare value.
- count  out  WIDTH  current LFSR state.
- offset  out  OFS_W  signed steps taken since the last load or reset.
- tc  out  1  one-cycle pulse: the state just stepped onto term_value.
- lock_err  out  1  sticky flag: a load of the lock-up value was rejected.

Behaviour:
- Reset (reset_n low, async assert, released on a clk edge):
  - count=0, offset=0, tc=0, lock_err=0.
  - All-zero is a legal XNOR state; all-ones is the lock-up state.
- Forward step (enable and up_down):
  - count <= {fb, count[WIDTH-1:1]}, where fb = ~^(count & TAPS).
  - offset <= offset+1.
- Reverse step (enable and !up_down):
  - count <= {count[WIDTH-2:0], rb}, where rb = ~^(count & RMASK) and RMASK = {1'b1, TAPS[WIDTH-1:1]}.
  - offset <= offset-1.
  - With the default TAPS, RMASK = 8'hB1.
- Invertibility: a forward step followed by a reverse step returns the exact original state, and vice versa.
- Load (load high):
  - Takes priority over enable; no step occurs that cycle.
  - If seed is not all-ones: count <= seed, offset <= 0.
  - If seed is all-ones: count and offset hold, lock_err <= 1.
  - lock_err is cleared only by reset.
- Priority: reset > load > enable > hold.
- tc:
  - Registered. Asserts for exactly one cycle after a step (either direction) whose next state equals term_value.
  - Not asserted by load, even when seed == term_value.
  - Not asserted while holding on term_value.
  - Back-to-back steps into term_value are impossible for WIDTH ≥ 3 (distinct consecutive states).
- offset: two's-complement, wraps modulo 2^OFS_W with no saturation.
- Latency: count, offset and tc all update on the same edge as the step. No combinational path from inputs to outputs.
- term_value may change at any time; it is sampled against the next state on the stepping edge.
- Reset mid-operation: immediate return to reset values, including clearing a pending tc.
- Lock-up state: unreachable except via the rejected load path, so no escape logic is required.

Decomposition:
- Package lfsr_pkg holds:
  - default tap constants per width (8, 16, 32);
  - the RMASK derivation function reverse_mask(TAPS);
  - a function lfsr_fwd(state, taps);
  - a function lfsr_rev(state, rmask).
- The bench reuses these functions as its reference model.
- One natural sub-module: lfsr_step_core. It is purely combinational: state, taps and direction in, next state out. lfsr_seq_gen wraps it with registers, load, compare and offset logic.

Test Plan:
- Reset then 3 forward steps, default params -> count 0x00→0x80→0xC0→0x60; offset 0→1→2→3.
- From 0x60, 1 reverse step -> count 0xC0, offset 2. Then 2 more reverse steps -> 0x00, offset 0.
- load with seed=0x5A, then 200 random-direction steps, compared cycle by cycle against lfsr_fwd/lfsr_rev -> exact match; offset equals net step count mod 256.
- term_value=0xC0, 2 forward steps from 0x00 -> tc high exactly one cycle after the edge entering 0xC0. Then load seed=0xC0 -> tc stays low.
- load with seed=0xFF while count=0x80 -> count stays 0x80, lock_err=1 and stays set. Assert reset_n low mid-run -> everything async-clears to 0.
- load and enable both high with seed=0x11 -> count=0x11, offset=0, no step. WIDTH=16 with TAPS=16'hB401 -> forward-then-reverse over 1000 steps returns to the start state.
